// File: rtl/prime_pkg.sv
// Shared definitions for the sequential prime generator: FSM states, default
// width and a reference prime-count function.
package prime_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CAND = 3'd1,
    DIV  = 3'd2,
    MOD  = 3'd3,
    EMIT = 3'd4,
    DONE = 3'd5
  } state_t;

  // Number of primes p with 2 <= p <= lim (reference only, not for synthesis).
  function automatic int unsigned prime_count(input int unsigned lim);
    int unsigned cnt;
    logic        is_p;
    cnt = 32'd0;
    for (int unsigned k = 32'd2; k <= lim; k++) begin
      is_p = 1'b1;
      for (int unsigned j = 32'd2; j * j <= k; j++) begin
        if (k % j == 32'd0) is_p = 1'b0;
      end
      if (is_p) cnt++;
    end
    return cnt;
  endfunction

endpackage

// File: rtl/prime_trial_div.sv
// Trial division of candidate n by repeated subtraction. One go pulse starts
// a test; is_prime or is_comp pulses for one cycle when the verdict is known.
module prime_trial_div
  import prime_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           go,
  input  logic [WIDTH:0] n,
  output logic           busy,
  output logic           is_prime,
  output logic           is_comp
);

  state_t               phase;
  state_t               phase_nxt;
  logic [WIDTH-1:0]     d;
  logic [WIDTH-1:0]     d_nxt;
  logic [WIDTH:0]       r;
  logic [WIDTH:0]       r_nxt;
  logic [WIDTH:0]       d_wide;
  logic [2*WIDTH-1:0]   d_ext;
  logic [2*WIDTH-1:0]   d_sq;
  logic [2*WIDTH-1:0]   n_ext;

  // d*d is formed at full 2*WIDTH precision so the sqrt bound never truncates
  assign d_wide = {1'b0, d};
  assign d_ext  = {{WIDTH{1'b0}}, d};
  assign d_sq   = d_ext * d_ext;
  assign n_ext  = {{(WIDTH-1){1'b0}}, n};
  assign busy   = (phase != IDLE);

  always_comb begin
    phase_nxt = phase;
    d_nxt     = d;
    r_nxt     = r;
    is_prime  = 1'b0;
    is_comp   = 1'b0;
    case (phase)
      DIV: begin
        if (d_sq > n_ext) begin
          is_prime  = 1'b1;
          phase_nxt = IDLE;
        end else begin
          r_nxt     = n;
          phase_nxt = MOD;
        end
      end
      MOD: begin
        if (r >= d_wide) begin
          r_nxt = r - d_wide;
        end else if (r == '0) begin
          is_comp   = 1'b1;
          phase_nxt = IDLE;
        end else begin
          d_nxt     = d + 1'b1;
          phase_nxt = DIV;
        end
      end
      default: begin
        if (go) begin
          d_nxt     = WIDTH'(2);
          phase_nxt = DIV;
        end else begin
          phase_nxt = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= IDLE;
      d     <= '0;
      r     <= '0;
    end else begin
      phase <= phase_nxt;
      d     <= d_nxt;
      r     <= r_nxt;
    end
  end

endmodule

// File: rtl/prime_gen.sv
// Sequential prime generator: enumerates primes 2..limit in ascending order
// over a valid/ready stream and pulses done at the end of each run.
module prime_gen
  import prime_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] prime,
  output logic             valid,
  input  logic             ready,
  output logic             busy,
  output logic             done
);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH:0]   n;
  logic [WIDTH:0]   n_nxt;
  logic [WIDTH-1:0] limit_q;
  logic [WIDTH-1:0] limit_q_nxt;
  logic             over;
  logic             go;
  logic             trial_busy;
  logic             is_prime;
  logic             is_comp;

  // n is one bit wider than limit so the final candidate limit+1 never wraps
  assign over = (n > {1'b0, limit_q});

  prime_trial_div #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .rst      (rst),
    .go       (go),
    .n        (n),
    .busy     (trial_busy),
    .is_prime (is_prime),
    .is_comp  (is_comp)
  );

  always_comb begin
    state_nxt   = state;
    n_nxt       = n;
    limit_q_nxt = limit_q;
    go          = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          limit_q_nxt = limit;
          n_nxt       = (WIDTH+1)'(2);
          state_nxt   = CAND;
        end else begin
          state_nxt = IDLE;
        end
      end
      CAND: begin
        if (over) begin
          state_nxt = DONE;
        end else if (!trial_busy) begin
          go        = 1'b1;
          state_nxt = DIV;
        end else begin
          state_nxt = CAND;
        end
      end
      DIV, MOD: begin
        if (is_prime) begin
          state_nxt = EMIT;
        end else if (is_comp) begin
          n_nxt     = n + 1'b1;
          state_nxt = CAND;
        end else begin
          state_nxt = state;
        end
      end
      EMIT: begin
        if (ready) begin
          n_nxt     = n + 1'b1;
          state_nxt = CAND;
        end else begin
          state_nxt = EMIT;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with the state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      n       <= '0;
      limit_q <= '0;
      prime   <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      n       <= n_nxt;
      limit_q <= limit_q_nxt;
      prime   <= (state_nxt == EMIT) ? n_nxt[WIDTH-1:0] : '0;
      valid   <= (state_nxt == EMIT);
      busy    <= (state_nxt inside {CAND, DIV, MOD, EMIT});
      done    <= (state_nxt == DONE);
    end
  end

endmodule
